one_to_n_demux: RTL and testbench
=================================

# one_to_n_demux

Routes a single valid/ready stream to one of N valid/ready output channels, selected per beat by a destination index carried with the data. It is the dispatch-side counterpart of the N-to-1 collection mux: samples leave a shared source (e.g. a TDC result FIFO) and fan out to N per-channel consumers. A 2-entry input skid buffer decouples `s_ready` from every `m_ready`, and a register on each output channel holds the routed beat.

## Interface
- `DATA_WIDTH`, default 32: payload width per beat.
- `N`, default 8: number of output channels, 2..16; need not be a power of two.
- `DEST_W`, default clog2(N) (minimum 1): width of the destination index.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready` at a rising edge.
- `s_data`  in  DATA_WIDTH  input payload.
- `s_dest`  in  DEST_W  destination channel index for the beat.
- `m_valid`  out  N  per-channel output valid.
- `m_ready`  in  N  per-channel output ready.
- `m_data`  out  N*DATA_WIDTH  channel k payload at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `drop_cnt`  out  16  dropped-beat counter; present only with `ONE_TO_N_DROP_CNT_EN`.

## Operation
- **Skid buffer:** 2 entries, each holding `{s_dest, s_data}`, with an occupancy count of 0..2.
  - `s_ready` = (count < 2), decoded from registered state only.
  - There is no combinational path from `m_ready` or `s_valid` to `s_ready`.
- **Head dispatch:**
  - Dispatch condition: the head entry (oldest) has `dest = d < N`, and output register d is free.
  - Output register d is free when `!m_valid[d] | m_ready[d]`.
  - When the condition holds, the head moves into output register d at the next edge, and the skid buffer pops.
- **Out-of-range destination** (`d >= N`):
  - The head is popped and discarded in one cycle.
  - No `m_valid` asserts for that beat.
- **Simultaneous push and pop** in one cycle: the count is unchanged, and the new beat enters behind the remaining entries.
- **Output register k:**
  - Loads on a dispatch to k, which sets `m_valid[k]` and loads `m_data` slice k.
  - Clears `m_valid[k]` on `m_valid[k] & m_ready[k]`, unless a new dispatch to k happens in the same cycle; in that case it reloads and stays valid.
- **Head-of-line blocking:** a head beat targeting a stalled channel blocks all later beats, whatever their destination. This is intentional: order is preserved per source.
- **`m_data` when invalid:** holds its last value; it is not cleared on drain.
- **Valid stability:**
  - Once `m_valid[k]` is high, it and `m_data` slice k hold until accepted.
  - `s_valid` is expected to follow the same rule (AXI-stream style); behaviour on withdrawal is undefined.

## Timing
- **Reset** (synchronous, sampled at the edge, takes priority over everything):
  - Skid count = 0, so `s_ready` = 1 in the cycle after reset.
  - `m_valid` = all zeros.
  - `m_data` = 0.
  - `drop_cnt` = 0.
- **Reset mid-operation:** all buffered and output beats are lost, and no handshake completes on the reset edge.
- **Latency:** a beat accepted at edge E0 shows `m_valid[d]` = 1 after edge E1, provided output d is free at E1. Minimum is 1 cycle of register latency after acceptance.
- **Throughput:** 1 beat/cycle sustained while destinations are drained every cycle; the count stays at 1 and `s_ready` stays at 1.
- **Full:** count = 2 gives `s_ready` = 0. It reasserts the cycle after a pop with no push.
- **Empty:** count = 0 means no dispatch and no drop.

## Configuration
- **Macro:** `ONE_TO_N_DROP_CNT_EN`.
- **Defined:**
  - Port `drop_cnt[15:0]` exists.
  - It increments by 1 on every out-of-range pop.
  - It saturates at 16'hFFFF and clears only on `reset`.
- **Undefined:**
  - The port and counter are absent.
  - Out-of-range beats are still silently discarded.

## Structure
- **Shared package:** `clog2` function, skid entry struct/typedef `{dest, data}`, `SKID_DEPTH = 2`.
- **Sub-module:** `stream_skid_buf` (2-entry valid/ready skid, registered ready). It is reusable on the mux side.
- **Top level:** dispatch logic, N output registers, and the optional counter.

## Test plan
- **Single beat:** after reset, `s_valid`=1, `s_dest`=3, `s_data`=32'hA5A5_0003, all `m_ready`=1 → `m_valid`=8'b0000_1000 exactly one cycle after acceptance, with `m_data` slice 3 = 32'hA5A5_0003.
- **Streaming:** 64 back-to-back beats with dest = i mod 8, all `m_ready`=1 → `s_ready` never drops, and each channel receives 8 beats in order.
- **Head-of-line stall:** `m_ready[2]`=0; send dest 2, 2, 5 → the first 2 is held in output 2, the second 2 sits in the skid, 5 stays queued, and `s_ready`=0 after count reaches 2. Raise `m_ready[2]` → order 2, 2, 5 completes.
- **Same-cycle reload:** channel 4 valid and draining while the next head targets 4 → `m_valid[4]` stays 1 and data updates without a bubble.
- **Out-of-range beat:** N=6, dest=7 → no `m_valid`. With `ONE_TO_N_DROP_CNT_EN`, `drop_cnt` reads 1 the next cycle; preload to 16'hFFFF → it stays at 16'hFFFF.
- **Reset mid-stream:** with count = 2 and 3 outputs valid, assert `reset` for 1 cycle → `m_valid`=0 and `s_ready`=1 after the edge.

Source files
------------

// File: rtl/one_to_n_demux_pkg.sv
// Shared definitions for the 1-to-N stream demux and its skid buffer.
package one_to_n_demux_pkg;

   localparam int SKID_DEPTH = 2;

   // Occupancy of the 2-entry skid buffer; the encoding equals the entry count.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   // Entry layout for the default build (DATA_WIDTH=32, N=8). The RTL packs
   // entries as a flat {dest, data} vector so that other widths work unchanged.
   typedef struct packed {
      logic [2:0]  dest;
      logic [31:0] data;
   } skid_entry_t;

   // Index width for a count of items, never less than 1.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << w) < value) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// 2-entry valid/ready skid buffer. s_ready and m_valid are registered, so
// there is no combinational path from m_ready or s_valid to s_ready.
//
// state      | meaning
// -----------+---------------------------------------------------------
// SKID_EMPTY | no entries held; m_valid=0, s_ready=1
// SKID_ONE   | entry[0] holds the head; m_valid=1, s_ready=1
// SKID_FULL  | entry[0] head, entry[1] behind it; m_valid=1, s_ready=0
module stream_skid_buf
   import one_to_n_demux_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   skid_state_e      state;
   logic [WIDTH-1:0] entry [SKID_DEPTH];
   logic             push;
   logic             pop;

   assign push   = s_valid & s_ready;
   assign pop    = m_valid & m_ready;
   assign m_data = entry[0];

   // Occupancy FSM with registered ready/valid; a push that coincides with a
   // pop lands behind whatever remains.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= SKID_EMPTY;
         s_ready <= 1'b1;
         m_valid <= 1'b0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else begin
         case (state)
            SKID_EMPTY: begin
               if (push) begin
                  entry[0] <= s_data;
                  state    <= SKID_ONE;
                  m_valid  <= 1'b1;
               end
            end
            SKID_ONE: begin
               if (push && pop) begin
                  entry[0] <= s_data;
               end else if (push) begin
                  entry[1] <= s_data;
                  state    <= SKID_FULL;
                  s_ready  <= 1'b0;
               end else if (pop) begin
                  state    <= SKID_EMPTY;
                  m_valid  <= 1'b0;
               end
            end
            SKID_FULL: begin
               if (pop) begin
                  entry[0] <= entry[1];
                  state    <= SKID_ONE;
                  s_ready  <= 1'b1;
               end
            end
            default: begin
               state   <= SKID_EMPTY;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/one_to_n_demux.sv
// 1-to-N valid/ready demux: a skid-buffered input stream is dispatched per
// beat to one of N registered output channels chosen by s_dest. A head beat
// whose channel is stalled blocks everything behind it, preserving source
// order. Beats with s_dest >= N are discarded.
// Optional feature: define ONE_TO_N_DROP_CNT_EN to add a saturating 16-bit
// drop_cnt port counting discarded out-of-range beats.
module one_to_n_demux
   import one_to_n_demux_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 8,
   parameter int DEST_W     = clog2(N)
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic [DEST_W-1:0]     s_dest,
   output logic [N-1:0]          m_valid,
   input  logic [N-1:0]          m_ready,
   output logic [N*DATA_WIDTH-1:0] m_data
`ifdef ONE_TO_N_DROP_CNT_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   localparam int ENTRY_W = DEST_W + DATA_WIDTH;

   logic                  head_valid;
   logic                  head_pop;
   logic [ENTRY_W-1:0]    head_entry;
   logic [DEST_W-1:0]     head_dest;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_in_range;
   logic                  drop;
   logic [N-1:0]          dispatch;

   stream_skid_buf #(
      .WIDTH (ENTRY_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  ({s_dest, s_data}),
      .m_valid (head_valid),
      .m_ready (head_pop),
      .m_data  (head_entry)
   );

   assign head_dest = head_entry[ENTRY_W-1 -: DEST_W];
   assign head_data = head_entry[DATA_WIDTH-1:0];

   // Pick the output register for the head beat; a head matching no channel
   // is out of range and is popped without dispatch.
   always_comb begin
      head_in_range = 1'b0;
      dispatch      = '0;
      for (int k = 0; k < N; k++) begin
         if (head_valid && (head_dest == DEST_W'(k))) begin
            head_in_range = 1'b1;
            dispatch[k]   = !m_valid[k] || m_ready[k];
         end
      end
      drop     = head_valid && !head_in_range;
      head_pop = (|dispatch) || drop;
   end

   // Output registers: load on dispatch (also when draining the same cycle),
   // otherwise clear valid on handshake. Data is kept after drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid <= '0;
         m_data  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (dispatch[k]) begin
               m_valid[k]                          <= 1'b1;
               m_data[k*DATA_WIDTH +: DATA_WIDTH] <= head_data;
            end else if (m_ready[k]) begin
               m_valid[k] <= 1'b0;
            end
         end
      end
   end

`ifdef ONE_TO_N_DROP_CNT_EN
   // Saturating count of discarded out-of-range beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_one_to_n_demux.sv
// Scoreboard bench for one_to_n_demux with N=6 (non power of two, so dest
// 6 and 7 are out of range). Accepted beats are queued per channel; a
// monitor pops and compares every output handshake.
module tb_one_to_n_demux;

   localparam int DW     = 32;
   localparam int N      = 6;
   localparam int DEST_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     s_data;
   logic [DEST_W-1:0] s_dest;
   logic [N-1:0]      m_valid;
   logic [N-1:0]      m_ready;
   logic [N*DW-1:0]   m_data;
`ifdef ONE_TO_N_DROP_CNT_EN
   logic [15:0]       drop_cnt;
`endif

   one_to_n_demux #(
      .DATA_WIDTH (DW),
      .N          (N),
      .DEST_W     (DEST_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_dest   (s_dest),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data)
`ifdef ONE_TO_N_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            exp_drops = 0;
   logic [DW-1:0] exp_q [N][$];
   logic [N-1:0]  prev_stall = '0;
   logic [DW-1:0] prev_data [N];
   logic          rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Random backpressure, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rand_ready) m_ready = N'($urandom);
   end

   // Monitor/scoreboard: handshakes seen at the falling edge complete at the
   // following rising edge.
   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) exp_q[k].delete();
         prev_stall = '0;
         exp_drops  = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (prev_stall[k]) begin
               check($sformatf("hold_valid_ch%0d", k), 64'(m_valid[k]), 64'd1);
               check($sformatf("hold_data_ch%0d", k), 64'(m_data[k*DW +: DW]), 64'(prev_data[k]));
            end
            if (m_valid[k] && m_ready[k]) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat_ch%0d: got data %0h required no beat at %0t",
                           k, m_data[k*DW +: DW], $time);
               end else begin
                  check($sformatf("data_ch%0d", k), 64'(m_data[k*DW +: DW]), 64'(exp_q[k].pop_front()));
               end
            end
            prev_stall[k] = m_valid[k] && !m_ready[k];
            prev_data[k]  = m_data[k*DW +: DW];
         end
         if (s_valid && s_ready) begin
            if (int'(s_dest) < N) exp_q[s_dest].push_back(s_data);
            else if (exp_drops < 65535) exp_drops++;
         end
      end
   end

   // Present one beat and hold it until accepted; returns just after the
   // accepting edge with the number of cycles spent waiting for s_ready.
   task automatic send(input logic [DEST_W-1:0] d, input logic [DW-1:0] v, output int stalls);
      stalls  = 0;
      s_valid = 1'b1;
      s_dest  = d;
      s_data  = v;
      @(negedge clk);
      while (!s_ready && stalls < 1000) begin
         @(negedge clk);
         stalls++;
      end
      if (stalls >= 1000) begin
         $display("FAIL send_timeout: got s_ready=0 for %0d cycles required acceptance", stalls);
         $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
         $fatal(1, "send timed out");
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      m_ready    = '1;
      repeat (5) @(posedge clk);
      #1;
      check("drain_m_valid", 64'(m_valid), 64'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish required finish before 2ms");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int total;
      logic [DW-1:0] v;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_dest  = '0;
      s_data  = '0;
      m_ready = '1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_m_valid", 64'(m_valid), 64'd0);
      check("reset_s_ready", 64'(s_ready), 64'd1);
      check("reset_m_data_lo", m_data[63:0], 64'd0);
      check("reset_m_data_hi", 64'(m_data[N*DW-1:64]), 64'd0);
`ifdef ONE_TO_N_DROP_CNT_EN
      check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

      // Single beat: visible exactly one edge after acceptance.
      send(3'd3, 32'hA5A5_0003, st);
      check("single_latency_min", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      check("single_m_valid", 64'(m_valid), 64'b001000);
      check("single_m_data", 64'(m_data[3*DW +: DW]), 64'h0000_0000_A5A5_0003);
      drain();

      // Streaming: no backpressure on the input.
      total = 0;
      for (int i = 0; i < 64; i++) begin
         send(DEST_W'(i % N), 32'h5000_0000 + i, st);
         total += st;
      end
      check("stream_s_ready_stalls", 64'(total), 64'd0);
      drain();

      // Head-of-line stall on channel 2.
      m_ready = 6'b111011;
      send(3'd2, 32'h2222_0001, st);
      send(3'd2, 32'h2222_0002, st);
      send(3'd5, 32'h5555_0003, st);
      check("hol_s_ready_full", 64'(s_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("hol_m_valid_blocked", 64'(m_valid), 64'b000100);
      check("hol_s_ready_still_full", 64'(s_ready), 64'd0);
      m_ready = '1;
      @(posedge clk); #1;
      check("hol_reload_m_valid", 64'(m_valid), 64'b000100);
      check("hol_s_ready_back", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      check("hol_last_m_valid", 64'(m_valid), 64'b100000);
      drain();

      // Same-cycle reload on channel 4.
      send(3'd4, 32'h4444_00AA, st);
      send(3'd4, 32'h4444_00BB, st);
      check("reload_first_valid", 64'(m_valid), 64'b010000);
      check("reload_first_data", 64'(m_data[4*DW +: DW]), 64'h4444_00AA);
      @(posedge clk); #1;
      check("reload_second_valid", 64'(m_valid), 64'b010000);
      check("reload_second_data", 64'(m_data[4*DW +: DW]), 64'h4444_00BB);
      drain();

      // Out-of-range destination is discarded.
      send(3'd7, 32'hDEAD_0007, st);
      @(posedge clk); #1;
      check("oor_no_valid", 64'(m_valid), 64'd0);
`ifdef ONE_TO_N_DROP_CNT_EN
      check("oor_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      @(posedge clk); #1;
      check("oor_no_valid_later", 64'(m_valid), 64'd0);
      drain();

      // Random traffic under random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         v = $urandom;
         send(DEST_W'($urandom_range(0, 7)), v, st);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();
      for (int k = 0; k < N; k++) begin
         check($sformatf("random_left_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
      end
`ifdef ONE_TO_N_DROP_CNT_EN
      check("random_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif

      // Reset with a full skid and three valid outputs.
      m_ready = '0;
      send(3'd0, 32'h0000_0A00, st);
      send(3'd1, 32'h0000_0A01, st);
      send(3'd3, 32'h0000_0A03, st);
      send(3'd0, 32'h0000_0B00, st);
      send(3'd1, 32'h0000_0B01, st);
      check("pre_reset_s_ready", 64'(s_ready), 64'd0);
      check("pre_reset_m_valid", 64'(m_valid), 64'b001011);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_m_valid", 64'(m_valid), 64'd0);
      check("midreset_s_ready", 64'(s_ready), 64'd1);
      check("midreset_m_data", m_data[63:0], 64'd0);
      m_ready = '1;
      repeat (4) @(posedge clk);
      #1;
      check("post_reset_idle", 64'(m_valid), 64'd0);

`ifdef ONE_TO_N_DROP_CNT_EN
      // Drive the drop counter into saturation.
      for (int i = 0; i < 65540; i++) begin
         send(3'd6, 32'(i), st);
      end
      @(posedge clk); #1;
      check("drop_cnt_saturated", 64'(drop_cnt), 64'hFFFF);
      check("drop_cnt_model", 64'(drop_cnt), 64'(exp_drops));
      send(3'd7, 32'h0, st);
      @(posedge clk); #1;
      check("drop_cnt_stays", 64'(drop_cnt), 64'hFFFF);
`endif

      drain();
      for (int k = 0; k < N; k++) begin
         check($sformatf("final_left_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
